// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry, line levels,
// and the baud divisor helper used by the transmitter and receiver.
// No logic, no latency; nothing here applies backpressure.
package uart_pkg;

  localparam int DATA_BITS = 8;

  // Line levels for the idle line and the start/stop bits.
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  // ST_PARITY is only visited when the parity bit is built in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Clocks per line bit; integer division, remainder dropped.
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// No latency of its own; tx_ready low stalls the producer.
// Ports: tx_data (byte), tx_valid (producer has a byte), tx_ready (sink can take it).
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with registered full/empty and head data readable combinationally.
// Latency: a push is visible at the head one clock later; a pop advances the head at the edge.
// Backpressure: push is ignored while full (even if a pop happens on the same edge); pop ignored while empty.
// Ports: clk, rst (sync, active high), push/push_dat, pop/pop_dat, full, empty.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             wr_en;
  logic             rd_en;

  // Gate on the registered flags so a same-edge pop never frees a slot early.
  assign wr_en   = push && !full;
  assign rd_en   = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (wr_en && !rd_en) begin
      count_nxt = count + CNT_ONE;
    end else if (!wr_en && rd_en) begin
      count_nxt = count - CNT_ONE;
    end
  end

  // Storage carries no reset; only pointers and flags define contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_nxt;
      full  <= (count_nxt == CNT_DEPTH);
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: queues bytes and sends 8-N-1 frames (8-E-1 with UART_TX_PARITY_EN defined).
// Latency: byte accepted at edge N is popped at N+1, start bit on tx from N+1; frames run back to back.
// Backpressure: tx_ready = !full from registered FIFO state; tx_valid ignored while full.
// Ports: clk, rst (sync, active high), tx_if (slave: tx_data/tx_valid/tx_ready),
//        tx (registered serial line, idle high), busy (frame in progress or bytes queued).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave tx_if,
  output logic     tx,
  output logic     busy
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W        = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  uart_state_t          state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  logic                 fifo_push;
  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_rd_dat;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 bit_done;

  assign tx_if.tx_ready = !fifo_full;
  assign fifo_push      = tx_if.tx_valid && !fifo_full;
  assign bit_done       = (baud_cnt == CNT_LAST);

  // Pop from IDLE, or at the last clock of the stop bit so the next start
  // bit follows with no idle gap.
  assign fifo_pop = !fifo_empty &&
                    ((state == ST_IDLE) || ((state == ST_STOP) && bit_done));

  assign busy = (state != ST_IDLE) || !fifo_empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (tx_if.tx_data),
    .pop      (fifo_pop),
    .pop_dat  (fifo_rd_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // tx is registered and always set one clock ahead of the bit it starts,
  // so every bit holds exactly CLKS_PER_BIT clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      tx       <= LINE_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= LINE_IDLE;
          if (fifo_pop) begin
            shreg    <= fifo_rd_dat;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^fifo_rd_dat;
`endif
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= LINE_START;
            state    <= ST_START;
          end
        end

        ST_START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shreg[0];
            shreg    <= {1'b0, shreg[DATA_BITS-1:1]};
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end

        ST_DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity_q;
              state <= ST_PARITY;
`else
              tx    <= LINE_STOP;
              state <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_done) begin
            baud_cnt <= '0;
            tx       <= LINE_STOP;
            state    <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
`endif

        ST_STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (fifo_pop) begin
              shreg    <= fifo_rd_dat;
`ifdef UART_TX_PARITY_EN
              parity_q <= ^fifo_rd_dat;
`endif
              bit_idx  <= '0;
              tx       <= LINE_START;
              state    <= ST_START;
            end else begin
              tx    <= LINE_IDLE;
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end

        default: begin
          baud_cnt <= '0;
          tx       <= LINE_IDLE;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at 16 clocks per bit: directed pushes feed a queue of
// expected bytes, and a line monitor decodes every frame and checks each bit.
// Build with UART_TX_PARITY_EN defined to exercise the 8-E-1 frame.
module tb_uart_tx;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  logic busy;

  uart_tx_if bus ();

  uart_tx #(
    .CLK_FREQ   (16),
    .BAUD       (1),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .tx_if (bus.slave),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, got, exp);
  endtask

  // Line level of each frame bit, index 0 = start bit.
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  // Scoreboard state
  logic [7:0] exp_q[$];
  int         starts[$];
  int         frames_started = 0;
  int         frames_done    = 0;
  int         unexp_frames   = 0;

  // Line monitor, sampling on the falling edge
  logic        mon_active = 1'b0;
  logic        mon_unexp  = 1'b0;
  logic [10:0] mon_exp;
  int          mon_cyc;
  int          mon_good;
  int          mon_bidx;

  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && tx === 1'b0) begin
        frames_started++;
        starts.push_back(cyc);
        mon_active = 1'b1;
        mon_cyc    = 0;
        mon_good   = 0;
        if (exp_q.size() == 0) begin
          mon_unexp = 1'b1;
          unexp_frames++;
          mon_exp = '1;
        end else begin
          mon_unexp = 1'b0;
          mon_exp   = frame_bits(exp_q.pop_front());
        end
      end
      if (mon_active) begin
        mon_bidx = mon_cyc / CPB;
        if (tx === mon_exp[mon_bidx]) mon_good++;
        if ((mon_cyc % CPB) == CPB - 1) begin
          if (!mon_unexp)
            check($sformatf("frame%0d_bit%0d_samples_ok", frames_started, mon_bidx), mon_good, CPB);
          mon_good = 0;
        end
        mon_cyc++;
        if (mon_cyc == FRAME) begin
          mon_active = 1'b0;
          frames_done++;
        end
      end
    end
  end

  // Step to the given cycle, landing 1 time unit after its rising edge.
  task automatic wait_cyc(input int target);
    do begin
      @(posedge clk); #1;
    end while (cyc < target);
  endtask

  // Offer a byte (caller at posedge+1); returns the accepting edge, or -1.
  task automatic push_byte(input logic [7:0] b, output int acc);
    logic rdy;
    int   waited;
    waited = 0;
    acc    = -1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = b;
    forever begin
      rdy = bus.tx_ready;
      @(posedge clk); #1;
      if (rdy) begin
        acc = cyc;
        exp_q.push_back(b);
        break;
      end
      waited++;
      if (waited > 2000) begin
        check("push_accept_timeout", 0, 1);
        break;
      end
    end
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int w;
    w = 0;
    while (frames_done < n && w < budget) begin
      @(posedge clk); #1;
      w++;
    end
    check(name, frames_done, n);
  endtask

  function automatic int last_start();
    return (starts.size() == 0) ? -1000000 : starts[starts.size()-1];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int s0;
    int base;
    int fd;
    int fs;
    int bad_tx;
    int bad_rdy;
    int bad_busy;

    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;

    // Reset and idle
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_tx", tx, 1);
    check("reset_tx_ready", bus.tx_ready, 1);
    check("reset_busy", busy, 0);
    bad_tx = 0; bad_rdy = 0; bad_busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) bad_tx++;
      if (bus.tx_ready !== 1'b1) bad_rdy++;
      if (busy !== 1'b0) bad_busy++;
    end
    check("idle_tx_bad_cycles", bad_tx, 0);
    check("idle_ready_bad_cycles", bad_rdy, 0);
    check("idle_busy_bad_cycles", bad_busy, 0);

    // Single byte 'T'
    push_byte(8'h54, acc);
    check("single_busy_after_accept", busy, 1);
    check("single_tx_high_at_accept", tx, 1);
    wait_cyc(acc + 2);
    s0 = last_start();
    check("single_start_latency", s0 - acc, 1);
    wait_cyc(s0 + FRAME - 1);
    check("single_busy_in_stop", busy, 1);
    wait_cyc(s0 + FRAME);
    check("single_busy_after_stop", busy, 0);
    check("single_tx_idle_after", tx, 1);
    wait_frames(1, 50, "single_frames_done");

    // Back-to-back 'A','M','I'
    base = starts.size();
    fd   = frames_done;
    push_byte(8'h41, acc);
    push_byte(8'h4D, acc);
    push_byte(8'h49, acc);
    wait_frames(fd + 3, 3 * FRAME + 50, "b2b_frames_done");
    if (starts.size() >= base + 3) begin
      check("b2b_gap_1_2", starts[base+1] - starts[base], FRAME);
      check("b2b_gap_2_3", starts[base+2] - starts[base+1], FRAME);
    end else begin
      check("b2b_frames_started", starts.size() - base, 3);
    end
    wait_cyc(cyc + 2);
    check("b2b_busy_after", busy, 0);
    check("b2b_queue_drained", exp_q.size(), 0);

    // Full FIFO: one byte on the line, four queued, a sixth held off
    base = starts.size();
    fd   = frames_done;
    push_byte(8'hA5, acc);
    wait_cyc(acc + 2);
    s0 = last_start();
    check("full_first_start_latency", s0 - acc, 1);
    push_byte(8'h3C, acc);
    push_byte(8'hC3, acc);
    push_byte(8'h0F, acc);
    push_byte(8'hF0, acc);
    check("full_ready_low", bus.tx_ready, 0);
    // Keep offering a byte while full; it must not be taken.
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h5A;
    wait_cyc(s0 + FRAME - 1);
    check("full_ready_low_before_pop", bus.tx_ready, 0);
    wait_cyc(s0 + FRAME);
    check("full_ready_high_after_pop", bus.tx_ready, 1);
    push_byte(8'h5A, acc);
    check("full_sixth_accept_edge", acc, s0 + FRAME + 1);
    wait_frames(fd + 6, 7 * FRAME, "full_frames_done");
    check("full_frames_started", starts.size() - base, 6);
    check("full_queue_drained", exp_q.size(), 0);

    // Reset during data bit 3 of 'M' with two bytes queued
    wait_cyc(cyc + 5);
    fs = frames_started;
    fd = frames_done;
    push_byte(8'h4D, acc);
    wait_cyc(acc + 2);
    s0 = last_start();
    push_byte(8'h11, acc);
    push_byte(8'h22, acc);
    wait_cyc(s0 + 70);
    check("midrst_tx_is_data_bit3", tx, 1);
    check("midrst_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_tx_after", tx, 1);
    check("midrst_busy_after", busy, 0);
    check("midrst_ready_after", bus.tx_ready, 1);
    exp_q.delete();
    bad_tx = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) bad_tx++;
    end
    check("midrst_tx_bad_cycles", bad_tx, 0);
    check("midrst_frames_started", frames_started - fs, 1);
    check("midrst_frames_completed", frames_done - fd, 0);
    check("unexpected_frames", unexp_frames, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter for the Basys3 UART design: it accepts bytes over a valid/ready handshake, queues them in a small FIFO and serializes each one as an 8-N-1 frame on `tx` at a fixed baud rate. It sits beside the receiver inside `Top`, running on the 100 MHz board clock with its own internal baud-tick counter. It is the transmit-side counterpart the receive path is tested against, and it can drive the receiver in loopback benches.

## Interface
- `CLK_FREQ`, 100_000_000, system clock frequency in Hz
- `BAUD`, 9600, line rate in bits per second
- `FIFO_DEPTH`, 4, byte queue depth; must be a power of two and at least 2
- `clk`  in  1  system clock, rising-edge active
- `rst`  in  1  synchronous, active-high reset
- `tx_data`  in  8  byte to send, sampled on accept
- `tx_valid`  in  1  producer has a byte
- `tx_ready`  out  1  FIFO can accept a byte
- `tx`  out  1  serial line, idle high, registered
- `busy`  out  1  frame in progress or FIFO non-empty

## Operation
- `CLKS_PER_BIT = CLK_FREQ / BAUD`, using integer division (10416 at the defaults). The bit counter is wide enough for `CLKS_PER_BIT-1`.
- Accept: a byte is written to the FIFO on any edge where `tx_valid && tx_ready`. `tx_ready = !full`, decoded from registered FIFO state.
- FSM states: IDLE, START, DATA, (PARITY), STOP.
- IDLE: `tx=1`. If the FIFO is non-empty, pop into a shift register, clear the bit counter and go to START.
- START: `tx=0` for `CLKS_PER_BIT` clocks.
- DATA: shift out 8 bits LSB first, each held for `CLKS_PER_BIT` clocks. A 3-bit index counts 0 to 7.
- STOP: `tx=1` for `CLKS_PER_BIT` clocks. Then:
  - if the FIFO is non-empty, pop and go directly to START, with no idle gap between frames;
  - otherwise go to IDLE.
- The shift register is loaded only at pop. Later FIFO writes never corrupt the frame in flight.
- `busy = (state != IDLE) || !empty`.
- Full FIFO: `tx_ready=0` and `tx_valid` is ignored. A pop on the same edge does not admit a write; `tx_ready` rises the following cycle.
- Empty FIFO with the FSM in IDLE: `tx` holds 1 indefinitely.

## Timing
- Reset values: `tx=1`, `tx_ready=1`, `busy=0`; FIFO empty; FSM in IDLE; all counters 0.
- Reset asserted mid-frame: on the next edge `tx=1` and the FIFO is flushed. The partial frame is truncated, not completed.
- Latency, with the FIFO empty and the FSM in IDLE:
  - byte accepted at edge N;
  - `busy=1` after edge N;
  - pop at edge N+1; `tx` falls after edge N+1.
- Frame length is exactly `10*CLKS_PER_BIT` clocks, or `11*CLKS_PER_BIT` with parity. Each bit is held an exact clock count with no drift.
- Throughput: one byte per frame time. `tx_ready` deasserts only when `FIFO_DEPTH` bytes are queued.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for `CLKS_PER_BIT` clocks, so the frame is 11 bits (8-E-1).
- `UART_TX_PARITY_EN` undefined: the PARITY state and its logic are absent; DATA goes directly to STOP, so the frame is 10 bits (8-N-1).

## Structure
- Package `uart_pkg` holds:
  - the FSM state encoding (shared with the receiver);
  - `DATA_BITS=8` and the idle/start/stop line levels;
  - the function computing `CLKS_PER_BIT` from `CLK_FREQ` and `BAUD`.
- Sub-module `uart_tx_fifo`: a synchronous FIFO with `FIFO_DEPTH` entries, push/pop ports, registered `full`/`empty`, and read data valid combinationally at head. The FSM, baud counter and shifter stay in `uart_tx`.

## Test plan
Benches run with `CLK_FREQ=16`, `BAUD=1`, giving `CLKS_PER_BIT=16`.
- Reset idle: hold `rst` 3 cycles then release, with no valid. Required: `tx=1`, `tx_ready=1`, `busy=0` for 100 cycles.
- Single byte: push 0x54 ('T'). Required: `tx` falls 1 cycle after accept, then line levels 0, 0,0,1,0,1,0,1,0, 1, each 16 cycles; `busy` drops after the stop bit ends.
- Back-to-back: push 0x41, 0x4D, 0x49 on consecutive cycles. Required: three contiguous 160-cycle frames with no idle gap; the decoded bytes match in order.
- Full FIFO: push 5 bytes while the first frame is active. Required: the 6th push is stalled (`tx_ready=0`), `tx_ready` returns 1 cycle after the next pop, and no byte is lost or duplicated.
- Mid-frame reset: assert `rst` during the DATA bit 3 of 0x4D with 2 bytes queued. Required: `tx=1` next cycle, `busy=0`, and no further frames are sent.
- Parity (`UART_TX_PARITY_EN`): push 0x54. Required: the parity bit is 1 (three ones in 0x54), held 16 cycles before the stop bit; total frame is 176 cycles.
